exception_sequencer: RTL and testbench

Multicycle-datapath sequencer for exception entry. It captures an exception request (invalid opcode, overflow, divide-by-zero) and saves the faulting PC into EPC. It then drives the IorD memory-address selector to the matching vector address, waits for the memory read, and loads PC with the zero-extended vector byte. It sits directly upstream of the IorD address mux and beside the main control FSM, which yields the datapath while `busy` is high.

---
 rtl/exception_sequencer.sv | 159 +++++++++++++++
 tb/tb_exception_sequencer.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exception_sequencer.sv
// ============================================================================
// Module   : exception_sequencer
// Purpose  : Multicycle exception-entry sequencer. It captures the exception
//            cause and EPC, steers IorD to the vector, then loads PC from the
//            vector byte. Define EX_NEST_EN to enable the one-entry pending
//            request register.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module exception_sequencer #(
    parameter int MEM_LAT = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ex_req_opcode,
    input  logic        ex_req_overflow,
    input  logic        ex_req_div0,
    input  logic [31:0] PC_in,
    input  logic [31:0] mem_data_in,
    output logic [2:0]  iord_sel,
    output logic        mem_wr,
    output logic [31:0] epc_out,
    output logic [31:0] pc_next,
    output logic        pc_load,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_LOAD = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [2:0] C_SEL_PC   = 3'b000;
    localparam logic [2:0] C_SEL_OPC  = 3'b011;
    localparam logic [2:0] C_SEL_OVF  = 3'b100;
    localparam logic [2:0] C_SEL_DIV0 = 3'b101;
    localparam logic [2:0] C_LAT_LAST = 3'(MEM_LAT - 1);

    state_t      r_state;
    logic [2:0]  r_cnt;
    logic [2:0]  r_sel;
    logic [31:0] r_epc;
    logic [31:0] r_pc_next;
    logic        r_pc_load;
    logic        r_busy;
    logic        r_done;

    logic        w_req_any;
    logic [2:0]  w_req_sel;
    logic        w_unused;

    // Only the vector byte of the read data is meaningful.
    assign w_unused  = &{1'b0, mem_data_in[31:8]};
    assign w_req_any = ex_req_opcode | ex_req_overflow | ex_req_div0;

    always_comb begin
        w_req_sel = C_SEL_PC;
        if (ex_req_opcode) begin
            w_req_sel = C_SEL_OPC;
        end else if (ex_req_overflow) begin
            w_req_sel = C_SEL_OVF;
        end else if (ex_req_div0) begin
            w_req_sel = C_SEL_DIV0;
        end
    end

`ifdef EX_NEST_EN
    logic        r_pend_vld;
    logic [2:0]  r_pend_sel;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= 3'd0;
            r_sel     <= C_SEL_PC;
            r_epc     <= 32'd0;
            r_pc_next <= 32'd0;
            r_pc_load <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
`ifdef EX_NEST_EN
            r_pend_vld <= 1'b0;
            r_pend_sel <= C_SEL_PC;
`endif
        end else begin
            r_pc_load <= 1'b0;
            r_done    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_req_any) begin
                        r_state <= S_ADDR;
                        r_sel   <= w_req_sel;
                        r_epc   <= PC_in - 32'd4;
                        r_cnt   <= 3'd0;
                        r_busy  <= 1'b1;
                    end
                end
                S_ADDR: begin
                    r_cnt <= r_cnt + 3'd1;
                    // Read data is sampled on the MEM_LAT-th edge after the address settled.
                    if (r_cnt == C_LAT_LAST) begin
                        r_state   <= S_LOAD;
                        r_pc_load <= 1'b1;
                        r_pc_next <= {24'b0, mem_data_in[7:0]};
                    end
                end
                S_LOAD: begin
                    r_state <= S_DONE;
                    r_done  <= 1'b1;
                end
                default: begin
`ifdef EX_NEST_EN
                    // An earlier pending entry wins over a request arriving now.
                    if (r_pend_vld || w_req_any) begin
                        r_state <= S_ADDR;
                        r_sel   <= r_pend_vld ? r_pend_sel : w_req_sel;
                        r_epc   <= PC_in - 32'd4;
                        r_cnt   <= 3'd0;
                    end else begin
                        r_state <= S_IDLE;
                        r_sel   <= C_SEL_PC;
                        r_busy  <= 1'b0;
                    end
`else
                    r_state <= S_IDLE;
                    r_sel   <= C_SEL_PC;
                    r_busy  <= 1'b0;
`endif
                end
            endcase
`ifdef EX_NEST_EN
            if ((r_state == S_ADDR) || (r_state == S_LOAD)) begin
                if (w_req_any && !r_pend_vld) begin
                    r_pend_vld <= 1'b1;
                    r_pend_sel <= w_req_sel;
                end
            end else if (r_state == S_DONE) begin
                r_pend_vld <= 1'b0;
            end
`endif
        end
    end

    assign iord_sel = r_sel;
    assign mem_wr   = 1'b0;
    assign epc_out  = r_epc;
    assign pc_next  = r_pc_next;
    assign pc_load  = r_pc_load;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule

`default_nettype wire

// File: tb/tb_exception_sequencer.sv
// ============================================================================
// Module   : tb_exception_sequencer
// Purpose  : Directed self-checking bench for exception_sequencer
//            (MEM_LAT = 2 main instance, MEM_LAT = 1 secondary instance).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_exception_sequencer;

    logic        clock;
    logic        reset;
    logic        ex_req_opcode;
    logic        ex_req_overflow;
    logic        ex_req_div0;
    logic [31:0] PC_in;
    logic [31:0] mem_data_in;

    logic [2:0]  iord_sel,  iord_sel1;
    logic        mem_wr,    mem_wr1;
    logic [31:0] epc_out,   epc_out1;
    logic [31:0] pc_next,   pc_next1;
    logic        pc_load,   pc_load1;
    logic        busy,      busy1;
    logic        done,      done1;

    int n_checks;
    int n_fail;

    exception_sequencer #(.MEM_LAT(2)) dut (
        .clock(clock), .reset(reset),
        .ex_req_opcode(ex_req_opcode), .ex_req_overflow(ex_req_overflow),
        .ex_req_div0(ex_req_div0), .PC_in(PC_in), .mem_data_in(mem_data_in),
        .iord_sel(iord_sel), .mem_wr(mem_wr), .epc_out(epc_out),
        .pc_next(pc_next), .pc_load(pc_load), .busy(busy), .done(done)
    );

    exception_sequencer #(.MEM_LAT(1)) dut1 (
        .clock(clock), .reset(reset),
        .ex_req_opcode(ex_req_opcode), .ex_req_overflow(ex_req_overflow),
        .ex_req_div0(ex_req_div0), .PC_in(PC_in), .mem_data_in(mem_data_in),
        .iord_sel(iord_sel1), .mem_wr(mem_wr1), .epc_out(epc_out1),
        .pc_next(pc_next1), .pc_load(pc_load1), .busy(busy1), .done(done1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(negedge clock);
    endtask

    task automatic clear_reqs();
        ex_req_opcode   = 1'b0;
        ex_req_overflow = 1'b0;
        ex_req_div0     = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_reqs();
        PC_in = 32'h0;
        mem_data_in = 32'h0;
        step();
        step();
        reset = 1'b0;
        n_checks++;
        if ({iord_sel, busy, done, pc_load, mem_wr} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got sel=%b busy=%b done=%b load=%b wr=%b, want all 0",
                     iord_sel, busy, done, pc_load, mem_wr);
        end
        n_checks++;
        if (epc_out !== 32'h0 || pc_next !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_regs: got epc=%h pc_next=%h, want 0/0", epc_out, pc_next);
        end
    endtask

    task automatic test_overflow();
        logic [2:0] exp_sel;
        PC_in = 32'h0000_0040;
        mem_data_in = 32'h0000_00A5;
        ex_req_overflow = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            step();
            clear_reqs();
            exp_sel = (c <= 4) ? 3'b100 : 3'b000;
            n_checks++;
            if (iord_sel !== exp_sel || busy !== (c <= 4)) begin
                n_fail++;
                $display("FAIL ovf_sel_busy c%0d: got sel=%b busy=%b, want sel=%b busy=%b",
                         c, iord_sel, busy, exp_sel, (c <= 4));
            end
            n_checks++;
            if (pc_load !== (c == 3) || done !== (c == 4) || mem_wr !== 1'b0) begin
                n_fail++;
                $display("FAIL ovf_load_done c%0d: got load=%b done=%b wr=%b, want load=%b done=%b wr=0",
                         c, pc_load, done, mem_wr, (c == 3), (c == 4));
            end
            if (c == 1) begin
                n_checks++;
                if (epc_out !== 32'h0000_003C) begin
                    n_fail++;
                    $display("FAIL ovf_epc: got %h want 0000003c", epc_out);
                end
            end
            if (c == 3 || c == 5) begin
                n_checks++;
                if (pc_next !== 32'h0000_00A5) begin
                    n_fail++;
                    $display("FAIL ovf_pc_next c%0d: got %h want 000000a5", c, pc_next);
                end
            end
        end
    endtask

    task automatic test_priority();
        PC_in = 32'h0000_0100;
        mem_data_in = 32'h0000_0033;
        ex_req_opcode = 1'b1;
        ex_req_overflow = 1'b1;
        ex_req_div0 = 1'b1;
        step();
        clear_reqs();
        n_checks++;
        if (iord_sel !== 3'b011 || epc_out !== 32'h0000_00FC) begin
            n_fail++;
            $display("FAIL prio: got sel=%b epc=%h, want 011/000000fc", iord_sel, epc_out);
        end
        for (int c = 2; c <= 7; c++) begin
            step();
            if (c >= 5) begin
                n_checks++;
                if (busy !== 1'b0 || iord_sel !== 3'b000 || pc_load !== 1'b0) begin
                    n_fail++;
                    $display("FAIL prio_single c%0d: got busy=%b sel=%b load=%b, want 0/000/0",
                             c, busy, iord_sel, pc_load);
                end
            end
        end
    endtask

    task automatic test_div0_pc0();
        PC_in = 32'h0000_0000;
        mem_data_in = 32'hFFFF_FF3C;
        ex_req_div0 = 1'b1;
        step();
        clear_reqs();
        n_checks++;
        if (epc_out !== 32'hFFFF_FFFC || iord_sel !== 3'b101) begin
            n_fail++;
            $display("FAIL div0_entry: got epc=%h sel=%b, want fffffffc/101", epc_out, iord_sel);
        end
        step();
        step();
        n_checks++;
        if (pc_load !== 1'b1 || pc_next !== 32'h0000_003C) begin
            n_fail++;
            $display("FAIL div0_load: got load=%b pc_next=%h, want 1/0000003c", pc_load, pc_next);
        end
        step();
        step();
        step();
    endtask

    task automatic test_reset_in_addr();
        PC_in = 32'h0000_0200;
        mem_data_in = 32'h0000_0077;
        ex_req_overflow = 1'b1;
        step();
        clear_reqs();
        n_checks++;
        if (busy !== 1'b1 || iord_sel !== 3'b100) begin
            n_fail++;
            $display("FAIL rst_addr_pre: got busy=%b sel=%b, want 1/100", busy, iord_sel);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_checks++;
        if ({iord_sel, busy, done, pc_load, mem_wr} !== 7'b0 ||
            epc_out !== 32'h0 || pc_next !== 32'h0) begin
            n_fail++;
            $display("FAIL rst_addr: got sel=%b busy=%b done=%b load=%b epc=%h pc_next=%h, want all 0",
                     iord_sel, busy, done, pc_load, epc_out, pc_next);
        end
        for (int c = 0; c < 4; c++) begin
            step();
            n_checks++;
            if (pc_load !== 1'b0 || busy !== 1'b0 || epc_out !== 32'h0) begin
                n_fail++;
                $display("FAIL rst_addr_after c%0d: got load=%b busy=%b epc=%h, want 0/0/0",
                         c, pc_load, busy, epc_out);
            end
        end
    endtask

    task automatic test_nest();
        PC_in = 32'h0000_0080;
        mem_data_in = 32'h0000_0011;
        ex_req_overflow = 1'b1;
        step();
        clear_reqs();
        step();
        ex_req_opcode = 1'b1;
        step();
        clear_reqs();
        n_checks++;
        if (pc_load !== 1'b1 || iord_sel !== 3'b100) begin
            n_fail++;
            $display("FAIL nest_first_load: got load=%b sel=%b, want 1/100", pc_load, iord_sel);
        end
        step();
        PC_in = 32'h0000_0504;
        n_checks++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL nest_first_done: got done=%b want 1", done);
        end
        for (int c = 5; c <= 9; c++) begin
            step();
`ifdef EX_NEST_EN
            n_checks++;
            if (busy !== (c <= 8) || iord_sel !== ((c <= 8) ? 3'b011 : 3'b000)) begin
                n_fail++;
                $display("FAIL nest_busy c%0d: got busy=%b sel=%b, want busy=%b sel=%b",
                         c, busy, iord_sel, (c <= 8), ((c <= 8) ? 3'b011 : 3'b000));
            end
            n_checks++;
            if (pc_load !== (c == 7) || done !== (c == 8) || epc_out !== 32'h0000_0500) begin
                n_fail++;
                $display("FAIL nest_seq c%0d: got load=%b done=%b epc=%h, want load=%b done=%b epc=00000500",
                         c, pc_load, done, epc_out, (c == 7), (c == 8));
            end
`else
            n_checks++;
            if (busy !== 1'b0 || iord_sel !== 3'b000 || pc_load !== 1'b0 ||
                epc_out !== 32'h0000_007C) begin
                n_fail++;
                $display("FAIL nonest c%0d: got busy=%b sel=%b load=%b epc=%h, want 0/000/0/0000007c",
                         c, busy, iord_sel, pc_load, epc_out);
            end
`endif
        end
        step();
    endtask

    task automatic test_memlat1();
        PC_in = 32'h0000_0020;
        mem_data_in = 32'h0000_0042;
        ex_req_div0 = 1'b1;
        step();
        clear_reqs();
        n_checks++;
        if (pc_load1 !== 1'b0 || iord_sel1 !== 3'b101 || busy1 !== 1'b1) begin
            n_fail++;
            $display("FAIL lat1_c1: got load=%b sel=%b busy=%b, want 0/101/1", pc_load1, iord_sel1, busy1);
        end
        step();
        n_checks++;
        if (pc_load1 !== 1'b1 || pc_next1 !== 32'h0000_0042 || pc_load !== 1'b0) begin
            n_fail++;
            $display("FAIL lat1_c2: got load1=%b pc_next1=%h load2=%b, want 1/00000042/0",
                     pc_load1, pc_next1, pc_load);
        end
        step();
        n_checks++;
        if (done1 !== 1'b1 || pc_load !== 1'b1) begin
            n_fail++;
            $display("FAIL lat1_c3: got done1=%b load2=%b, want 1/1", done1, pc_load);
        end
        step();
        n_checks++;
        if (busy1 !== 1'b0 || done !== 1'b1) begin
            n_fail++;
            $display("FAIL lat1_c4: got busy1=%b done2=%b, want 0/1", busy1, done);
        end
        step();
        step();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_overflow();
        test_priority();
        test_div0_pc0();
        test_reset_in_addr();
        test_nest();
        test_memlat1();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
